acc_spi_onchip_mem_arbiter: RTL and testbench

//  Shares one single-port on-chip RAM (32-bit, 1-cycle read latency) between two Avalon-MM

---
 rtl/acc_spi_mem_pkg.sv | 8 +
 rtl/acc_spi_rr_arb2.sv | 38 +++
 rtl/acc_spi_onchip_mem_arbiter.sv | 82 ++++++++
 tb/tb_acc_spi_onchip_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_spi_mem_pkg.sv
// acc_spi_mem_pkg: shared defaults and port identifiers for the on-chip RAM arbiter.
package acc_spi_mem_pkg;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH = 10240;
  localparam int DEF_MAX_BURST = 4;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_id_t;
endpackage

// File: rtl/acc_spi_rr_arb2.sv
// acc_spi_rr_arb2: two-input round-robin grant with a bounded burst to the last winner.
module acc_spi_rr_arb2 import acc_spi_mem_pkg::*; #(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output port_id_t   last
);
  localparam int CW = $clog2(MAX_BURST + 1);
  port_id_t last_q, last_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic keep;
  always_comb begin
    // a zero count means no burst in progress, so ties go to the other port
    keep = (cnt_q != '0) && (cnt_q < CW'(MAX_BURST));
    win = (req == 2'b01) ? PORT_A :
          (req == 2'b10) ? PORT_B :
          keep ? last_q : (last_q == PORT_A ? PORT_B : PORT_A);
    gnt = ~|req ? 2'b00 : (win == PORT_B ? 2'b10 : 2'b01);
    last_d = accept ? win : last_q;
    cnt_d = ~|req ? '0 :
            !accept ? cnt_q :
            (win == last_q) ? (cnt_q == CW'(MAX_BURST) ? cnt_q : cnt_q + 1'b1) : CW'(1);
    last = last_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= PORT_B;
      cnt_q <= '0;
    end else begin
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/acc_spi_onchip_mem_arbiter.sv
// acc_spi_onchip_mem_arbiter: shares the RAM s1 port between the Nios data master (A) and the SPI sample writer (B).
module acc_spi_onchip_mem_arbiter import acc_spi_mem_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_byteenable,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [DATA_W-1:0]   a_writedata,
  output logic                a_waitrequest,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [DATA_W-1:0]   b_writedata,
  output logic                b_waitrequest,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                err_oor
);
  logic [1:0] gnt;
  port_id_t last;
  logic accept, sel_b, wr, rd, in_range;
  logic rdv_q, rdv_d, oor_q, oor_d, err_q, err_d;
  acc_spi_rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk(clk),
    .reset(reset),
    .req({b_read | b_write, a_read | a_write}),
    .accept(accept),
    .gnt(gnt),
    .last(last)
  );
  always_comb begin
    accept = |gnt & ~reset;
    sel_b = gnt[1];
    wr = sel_b ? b_write : a_write;
    rd = (sel_b ? b_read : a_read) & ~wr;
    mem_address = sel_b ? b_address : a_address;
    mem_byteenable = sel_b ? b_byteenable : a_byteenable;
    mem_writedata = sel_b ? b_writedata : a_writedata;
    in_range = int'(mem_address) < DEPTH;
    mem_chipselect = accept;
    mem_write = accept & wr & in_range;
    mem_clken = 1'b1;
    a_waitrequest = ~(accept & ~sel_b);
    b_waitrequest = ~(accept & sel_b);
    rdv_d = accept & rd;
    oor_d = ~in_range;
    err_d = err_q | (accept & ~in_range);
    // last always names the previous cycle's winner, which is the owner of a pending read
    a_readdatavalid = rdv_q & (last == PORT_A);
    b_readdatavalid = rdv_q & (last == PORT_B);
    a_readdata = (a_readdatavalid & ~oor_q) ? mem_readdata : '0;
    b_readdata = (b_readdatavalid & ~oor_q) ? mem_readdata : '0;
    err_oor = err_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdv_q <= 1'b0;
      oor_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rdv_q <= rdv_d;
      oor_q <= oor_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_acc_spi_onchip_mem_arbiter.sv
// tb_acc_spi_onchip_mem_arbiter: random and directed traffic scored against a behavioural arbiter/RAM model.
module tb_acc_spi_onchip_mem_arbiter;
  localparam int MB = 4;
  localparam int DEPTH = 10240;
  typedef struct {logic rd; logic wr; logic [13:0] addr; logic [3:0] be; logic [31:0] data;} cmd_t;
  typedef struct {int port; logic [31:0] data; int due;} exp_t;
  logic clk = 0, reset = 1;
  logic [13:0] a_address = 0, b_address = 0, mem_address;
  logic [3:0] a_byteenable = 0, b_byteenable = 0, mem_byteenable;
  logic a_read = 0, a_write = 0, b_read = 0, b_write = 0;
  logic [31:0] a_writedata = 0, b_writedata = 0, a_readdata, b_readdata, mem_writedata, mem_readdata;
  logic a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid;
  logic mem_chipselect, mem_write, mem_clken, err_oor;
  cmd_t cqa[$], cqb[$];
  exp_t sb[$];
  int cyc = 0;
  int ncmp_c = 0, nfail_c = 0, ncmp_m = 0, nfail_m = 0, ncmp_t = 0, nfail_t = 0;
  int m_last = 1, m_streak = 0;
  bit m_err = 0, acc_a = 0, acc_b = 0;
  logic [31:0] ref_mem [0:16383];
  logic [31:0] ram [0:16383];
  logic [31:0] ram_q;

  acc_spi_onchip_mem_arbiter #(.ADDR_W(14), .DATA_W(32), .DEPTH(DEPTH), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read), .a_write(a_write),
    .a_writedata(a_writedata), .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read), .b_write(b_write),
    .b_writedata(b_writedata), .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
    .b_readdatavalid(b_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .err_oor(err_oor)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // single-port RAM with one cycle of read latency
  always @(posedge clk) begin
    if (mem_chipselect && mem_write)
      for (int i = 0; i < 4; i++)
        if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
    ram_q <= ram[mem_address];
  end
  assign mem_readdata = ram_q;

  task automatic chk_c(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp_c++;
    if (act !== exp) begin
      nfail_c++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  task automatic chk_m(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp_m++;
    if (act !== exp) begin
      nfail_m++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  // reference model: grant prediction, memory contents, sticky error, expected read responses
  always @(negedge clk) begin
    int win;
    bit ra, rb, w, inr;
    logic [13:0] ad;
    logic [3:0] be;
    logic [31:0] wd, nv;
    if (reset) begin
      chk_c("rst_a_wait", a_waitrequest, 1);
      chk_c("rst_b_wait", b_waitrequest, 1);
      chk_c("rst_cs", mem_chipselect, 0);
      chk_c("rst_mem_write", mem_write, 0);
      chk_c("rst_err_oor", err_oor, 0);
      m_last <= 1;
      m_streak <= 0;
      m_err <= 0;
      acc_a <= 0;
      acc_b <= 0;
    end else begin
      ra = a_read | a_write;
      rb = b_read | b_write;
      win = (ra && rb) ? ((m_streak > 0 && m_streak < MB) ? m_last : 1 - m_last) : ra ? 0 : rb ? 1 : -1;
      chk_c("a_wait", a_waitrequest, win != 0);
      chk_c("b_wait", b_waitrequest, win != 1);
      chk_c("cs", mem_chipselect, win >= 0);
      chk_c("err_oor", err_oor, m_err);
      chk_c("clken", mem_clken, 1);
      if (win >= 0) begin
        w = win ? b_write : a_write;
        ad = win ? b_address : a_address;
        be = win ? b_byteenable : a_byteenable;
        wd = win ? b_writedata : a_writedata;
        inr = int'(ad) < DEPTH;
        chk_c("mem_addr", mem_address, ad);
        chk_c("mem_write", mem_write, w && inr);
        if (w && inr) begin
          chk_c("mem_wdata", mem_writedata, wd);
          chk_c("mem_be", mem_byteenable, be);
          nv = ref_mem[ad];
          for (int i = 0; i < 4; i++) if (be[i]) nv[8*i +: 8] = wd[8*i +: 8];
          ref_mem[ad] <= nv;
        end
        if (!w) sb.push_back('{win, inr ? ref_mem[ad] : 32'd0, cyc + 1});
        if (!inr) m_err <= 1;
        m_streak <= (win == m_last) ? m_streak + 1 : 1;
        m_last <= win;
      end else m_streak <= 0;
      acc_a <= (win == 0);
      acc_b <= (win == 1);
    end
  end

  // response monitor: pops the scoreboard whenever a readdatavalid appears
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      chk_m("rst_rdv", {a_readdatavalid, b_readdatavalid}, 0);
    end else begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        ncmp_m++;
        nfail_m++;
        $display("FAIL rdv_missing: port %0d got no valid, required one at cycle %0d", sb[0].port, sb[0].due);
        void'(sb.pop_front());
      end
      if (a_readdatavalid || b_readdatavalid) begin
        if (sb.size() == 0 || sb[0].due != cyc) begin
          ncmp_m++;
          nfail_m++;
          $display("FAIL rdv_spurious: got valid a=%b b=%b, required none at cycle %0d", a_readdatavalid, b_readdatavalid, cyc);
        end else begin
          e = sb.pop_front();
          chk_m("rdv_port", {a_readdatavalid, b_readdatavalid}, e.port ? 2'b01 : 2'b10);
          chk_m("rdata", e.port ? b_readdata : a_readdata, e.data);
          chk_m("other_rdata", e.port ? a_readdata : b_readdata, 0);
        end
      end
    end
  end

  task automatic drive();
    a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    if (cqa.size() > 0) begin
      a_read = cqa[0].rd; a_write = cqa[0].wr; a_address = cqa[0].addr;
      a_byteenable = cqa[0].be; a_writedata = cqa[0].data;
    end
    if (cqb.size() > 0) begin
      b_read = cqb[0].rd; b_write = cqb[0].wr; b_address = cqb[0].addr;
      b_byteenable = cqb[0].be; b_writedata = cqb[0].data;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (acc_a && cqa.size() > 0) void'(cqa.pop_front());
    if (acc_b && cqb.size() > 0) void'(cqb.pop_front());
    drive();
  endtask

  task automatic drain();
    int n = 0;
    while ((cqa.size() > 0 || cqb.size() > 0) && n < 200) begin
      step();
      n++;
    end
    ncmp_t++;
    if (cqa.size() > 0 || cqb.size() > 0) begin
      nfail_t++;
      $display("FAIL drain: %0d/%0d commands still queued, required 0/0", cqa.size(), cqb.size());
    end
    repeat (2) step();
  endtask

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    int r = $urandom % 20;
    int s = $urandom % 10;
    c.rd = (r < 10) || (r == 19);
    c.wr = (r >= 10);
    c.addr = (s < 8) ? 14'($urandom % 64) :
             (s == 8) ? (($urandom % 2) ? 14'h27FF : 14'h2800) :
             14'(10240 + $urandom % 6144);
    c.be = 4'($urandom);
    c.data = $urandom;
    return c;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    cqa.push_back('{1'b0, 1'b1, 14'h0010, 4'hF, 32'hDEAD_BEEF});
    cqa.push_back('{1'b1, 1'b0, 14'h0010, 4'hF, 32'h0});
    drain();
    cqb.push_back('{1'b0, 1'b1, 14'h0020, 4'hF, 32'hFFFF_FFFF});
    cqb.push_back('{1'b0, 1'b1, 14'h0020, 4'b0011, 32'h1234_5678});
    cqb.push_back('{1'b1, 1'b0, 14'h0020, 4'hF, 32'h0});
    drain();
    cqa.push_back('{1'b0, 1'b1, 14'h2800, 4'hF, 32'hA5A5_A5A5});
    cqa.push_back('{1'b1, 1'b0, 14'h2800, 4'hF, 32'h0});
    cqa.push_back('{1'b1, 1'b0, 14'h27FF, 4'hF, 32'h0});
    cqa.push_back('{1'b0, 1'b1, 14'h27FF, 4'hF, 32'h0BAD_F00D});
    cqa.push_back('{1'b1, 1'b0, 14'h27FF, 4'hF, 32'h0});
    drain();
    for (int i = 0; i < 10; i++) cqa.push_back('{1'b1, 1'b0, 14'h0010, 4'hF, 32'h0});
    step();
    step();
    for (int i = 0; i < 3; i++) cqb.push_back('{1'b1, 1'b0, 14'h0020, 4'hF, 32'h0});
    drain();
    for (int i = 0; i < 64; i++) cqa.push_back('{1'b0, 1'b1, 14'(i), 4'hF, $urandom});
    drain();
    repeat (800) begin
      if (cqa.size() == 0 && $urandom % 10 < 7) cqa.push_back(rnd_cmd());
      if (cqb.size() == 0 && $urandom % 10 < 7) cqb.push_back(rnd_cmd());
      step();
    end
    drain();
    cqa.push_back('{1'b1, 1'b0, 14'h0010, 4'hF, 32'h0});
    step();
    @(posedge clk);
    #1 reset = 1;
    cqa.delete();
    cqb.delete();
    drive();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    repeat (5) step();
    cqb.push_back('{1'b1, 1'b0, 14'h0020, 4'hF, 32'h0});
    cqa.push_back('{1'b1, 1'b0, 14'h0010, 4'hF, 32'h0});
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp_c + ncmp_m + ncmp_t, nfail_c + nfail_m + nfail_t);
    $finish;
  end
endmodule
